// File: rtl/fetch_stage.sv
// IF stage with IF/ID pipeline register: owns the PC, captures fetched instructions,
// tracks the opcode history for hazard detection and keeps saturating stall/flush counters.
module fetch_stage #(
    parameter int unsigned         PC_W      = 32,
    parameter int unsigned         INSTR_W   = 32,
    parameter logic [PC_W-1:0]     RESET_PC  = 32'h0000_0000,
    parameter logic [PC_W-1:0]     PC_STEP   = 32'd4,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0000,
    parameter int unsigned         CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_decode,
    input  logic               stall_fetch,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic [3:0]         cur_opcode,
    output logic [3:0]         prev_opcode,
    output logic [3:0]         prev2_opcode,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count
);

    localparam logic [3:0] NOP_OP = NOP_INSTR[INSTR_W-1:INSTR_W-4];

    typedef enum logic [1:0] {
        ACT_NORMAL = 2'd0,
        ACT_STALLF = 2'd1,
        ACT_STALLD = 2'd2,
        ACT_BRANCH = 2'd3
    } action_t;

    action_t              action_s;
    logic [PC_W-1:0]      pc_r;
    logic [INSTR_W-1:0]   ifid_instr_r;
    logic [PC_W-1:0]      ifid_pc_r;
    logic                 ifid_valid_r;
    logic [3:0]           prev_opcode_r;
    logic [3:0]           prev2_opcode_r;
    logic [CNT_W-1:0]     stall_cycles_r;
    logic [CNT_W-1:0]     flush_count_r;
    logic [3:0]           cur_opcode_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            sat_inc = value;
        end else begin
            sat_inc = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign cur_opcode_s = ifid_instr_r[INSTR_W-1:INSTR_W-4];

    // Pick exactly one action per cycle: redirect beats decode stall beats fetch stall.
    always_comb begin
        action_s = ACT_NORMAL;
        if (branch_taken) begin
            action_s = ACT_BRANCH;
        end else if (stall_decode) begin
            action_s = ACT_STALLD;
        end else if (stall_fetch) begin
            action_s = ACT_STALLF;
        end else begin
            action_s = ACT_NORMAL;
        end
    end

    // PC, IF/ID register, opcode history and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r           <= RESET_PC;
            ifid_instr_r   <= NOP_INSTR;
            ifid_pc_r      <= '0;
            ifid_valid_r   <= 1'b0;
            prev_opcode_r  <= NOP_OP;
            prev2_opcode_r <= NOP_OP;
            stall_cycles_r <= '0;
            flush_count_r  <= '0;
        end else begin
            case (action_s)
                ACT_BRANCH: begin
                    pc_r           <= branch_target;
                    ifid_instr_r   <= NOP_INSTR;
                    ifid_pc_r      <= '0;
                    ifid_valid_r   <= 1'b0;
                    prev_opcode_r  <= NOP_OP;
                    prev2_opcode_r <= NOP_OP;
                    flush_count_r  <= sat_inc(flush_count_r);
                end
                ACT_STALLD: begin
                    // Decode holds its instruction, so execute receives a bubble.
                    prev_opcode_r  <= NOP_OP;
                    prev2_opcode_r <= prev_opcode_r;
                    stall_cycles_r <= sat_inc(stall_cycles_r);
                end
                ACT_STALLF: begin
                    ifid_instr_r   <= NOP_INSTR;
                    ifid_pc_r      <= '0;
                    ifid_valid_r   <= 1'b0;
                    prev_opcode_r  <= cur_opcode_s;
                    prev2_opcode_r <= prev_opcode_r;
                    stall_cycles_r <= sat_inc(stall_cycles_r);
                end
                ACT_NORMAL: begin
                    pc_r           <= pc_r + PC_STEP;
                    ifid_instr_r   <= imem_rdata;
                    ifid_pc_r      <= pc_r;
                    ifid_valid_r   <= 1'b1;
                    prev_opcode_r  <= cur_opcode_s;
                    prev2_opcode_r <= prev_opcode_r;
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign imem_addr    = pc_r;
    assign ifid_instr   = ifid_instr_r;
    assign ifid_pc      = ifid_pc_r;
    assign ifid_valid   = ifid_valid_r;
    assign cur_opcode   = cur_opcode_s;
    assign prev_opcode  = prev_opcode_r;
    assign prev2_opcode = prev2_opcode_r;
    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model pushes the expected state per
// driven cycle, and the observed outputs are popped and compared after each edge.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_decode;
    logic        stall_fetch;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic [3:0]  cur_opcode;
    logic [3:0]  prev_opcode;
    logic [3:0]  prev2_opcode;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic [3:0]  imem_hi;

    logic        rst_n_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic [31:0] ifid_instr_w;
    logic [31:0] ifid_pc_w;
    logic        ifid_valid_w;
    logic [3:0]  cur_opcode_w;
    logic [3:0]  prev_opcode_w;
    logic [3:0]  prev2_opcode_w;
    logic [15:0] stall_cycles_w;
    logic [15:0] flush_count_w;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic [3:0]  prev;
        logic [3:0]  prev2;
        logic [15:0] stall;
        logic [15:0] flush;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .stall_decode(stall_decode), .stall_fetch(stall_fetch),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .cur_opcode(cur_opcode), .prev_opcode(prev_opcode), .prev2_opcode(prev2_opcode),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n_w),
        .stall_decode(1'b0), .stall_fetch(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0000_0000),
        .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .ifid_instr(ifid_instr_w), .ifid_pc(ifid_pc_w), .ifid_valid(ifid_valid_w),
        .cur_opcode(cur_opcode_w), .prev_opcode(prev_opcode_w), .prev2_opcode(prev2_opcode_w),
        .stall_cycles(stall_cycles_w), .flush_count(flush_count_w)
    );

    assign imem_rdata   = {imem_hi, imem_addr[27:0]};
    assign imem_rdata_w = {4'h2, imem_addr_w[27:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic void model_reset();
        m.pc = 32'h0; m.instr = 32'h0; m.ipc = 32'h0; m.valid = 1'b0;
        m.prev = 4'h0; m.prev2 = 4'h0; m.stall = 16'h0; m.flush = 16'h0;
    endfunction

    function automatic void model_step(input logic sd, input logic sf, input logic br,
                                       input logic [31:0] tgt, input logic [3:0] hi);
        logic [3:0] cur;
        cur = m.instr[31:28];
        if (br) begin
            m.pc = tgt; m.instr = 32'h0; m.ipc = 32'h0; m.valid = 1'b0;
            m.prev = 4'h0; m.prev2 = 4'h0; m.flush = sat16(m.flush);
        end else if (sd) begin
            m.prev2 = m.prev; m.prev = 4'h0; m.stall = sat16(m.stall);
        end else if (sf) begin
            m.prev2 = m.prev; m.prev = cur;
            m.instr = 32'h0; m.ipc = 32'h0; m.valid = 1'b0; m.stall = sat16(m.stall);
        end else begin
            m.instr = {hi, m.pc[27:0]}; m.ipc = m.pc; m.valid = 1'b1;
            m.prev2 = m.prev; m.prev = cur; m.pc = m.pc + 32'd4;
        end
    endfunction

    task automatic compare_outputs(input exp_t e);
        check("imem_addr", imem_addr, e.pc);
        check("ifid_instr", ifid_instr, e.instr);
        check("ifid_pc", ifid_pc, e.ipc);
        check("ifid_valid", ifid_valid, e.valid);
        check("cur_opcode", cur_opcode, e.instr[31:28]);
        check("prev_opcode", prev_opcode, e.prev);
        check("prev2_opcode", prev2_opcode, e.prev2);
        check("stall_cycles", stall_cycles, e.stall);
        check("flush_count", flush_count, e.flush);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic sd, input logic sf, input logic br,
                        input logic [31:0] tgt, input logic [3:0] hi);
        exp_t e;
        stall_decode = sd; stall_fetch = sf; branch_taken = br; branch_target = tgt;
        imem_hi = hi;
        model_step(sd, sf, br, tgt, hi);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            compare_outputs(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        stall_decode = 1'b0; stall_fetch = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_outputs(m);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; rst_n_w = 1'b0; imem_hi = 4'h1;
        stall_decode = 1'b0; stall_fetch = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        @(negedge clk);

        // Free-running fetch.
        do_reset();
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0, 4'h1);
        check("free_pc", imem_addr, 64'h10);
        check("free_op", cur_opcode, 64'h1);

        // Decode stall holding opcode A at pc 8.
        do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 4'hA);
        step(1'b1, 1'b0, 1'b0, 32'h0, 4'h5);
        check("stalld_prev1", prev_opcode, 64'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 4'h5);
        check("stalld_pc", imem_addr, 64'hC);
        check("stalld_ifid_pc", ifid_pc, 64'h8);
        check("stalld_op", cur_opcode, 64'hA);
        check("stalld_cnt", stall_cycles, 64'd2);

        // Fetch stall with opcode C in decode.
        step(1'b0, 1'b0, 1'b0, 32'h0, 4'hC);
        step(1'b0, 1'b1, 1'b0, 32'h0, 4'h7);
        check("stallf_valid", ifid_valid, 64'd0);
        check("stallf_prev", prev_opcode, 64'hC);
        check("stallf_pc", imem_addr, 64'h10);

        // Branch overrides a simultaneous decode stall.
        step(1'b1, 1'b0, 1'b1, 32'h40, 4'h3);
        check("br_pc", imem_addr, 64'h40);
        check("br_flush", flush_count, 64'd1);
        check("br_stall", stall_cycles, 64'd3);
        step(1'b0, 1'b0, 1'b0, 32'h0, 4'h3);
        check("br_target_fetch", ifid_pc, 64'h40);

        // Mixed random traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), {$urandom_range(0, 255), 2'b00}, 4'($urandom));
        end

        // Stall counter saturation, then asynchronous reset in the middle of a stall.
        for (int i = 0; i < 32'h1_0000; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 4'h6);
        end
        check("stall_sat", stall_cycles, 64'hFFFF);
        stall_decode = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs(m);
        stall_decode = 1'b0;
        @(negedge clk);

        // PC wrap from the top of the address space.
        rst_n_w = 1'b1;
        @(posedge clk); #1;
        check("wrap_ifid_pc0", ifid_pc_w, 64'hFFFF_FFFC);
        check("wrap_pc0", imem_addr_w, 64'h0);
        @(posedge clk); #1;
        check("wrap_ifid_pc1", ifid_pc_w, 64'h0);
        check("wrap_pc1", imem_addr_w, 64'h4);
        check("wrap_valid", ifid_valid_w, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
